// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES hash result words from shared memory and reports the minimum, its nonce and the target hit count.
// Optional macro SCAN_WRITEBACK_EN appends a two-word summary write after the scan.
module hash_result_scan #(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic [31:0]       target,
  output logic              done,
  output logic              busy,
  output logic              found,
  output logic [7:0]        best_nonce,
  output logic [31:0]       best_hash,
  output logic [7:0]        match_count,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
`ifdef SCAN_WRITEBACK_EN
    S_WB0,
    S_WB1,
`endif
    S_DONE
  } state_t;

  localparam logic [8:0] N_CNT = 9'(NUM_NONCES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       target_q, target_d;
  logic [8:0]        issue_cnt_q, issue_cnt_d;
  logic [8:0]        cap_idx_q, cap_idx_d;
  logic [1:0]        pend_q, pend_d;
  logic [31:0]       best_hash_q, best_hash_d;
  logic [7:0]        best_nonce_q, best_nonce_d;
  logic [7:0]        match_cnt_q, match_cnt_d;
  logic              found_q, found_d;
`ifdef SCAN_WRITEBACK_EN
  localparam logic [ADDR_W-1:0] N_ADDR = ADDR_W'(NUM_NONCES);
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       wdata_q, wdata_d;
`endif

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    target_d     = target_q;
    issue_cnt_d  = issue_cnt_q;
    cap_idx_d    = cap_idx_q;
    pend_d       = {pend_q[0], 1'b0};
    best_hash_d  = best_hash_q;
    best_nonce_d = best_nonce_q;
    match_cnt_d  = match_cnt_q;
    found_d      = found_q;
`ifdef SCAN_WRITEBACK_EN
    base_d       = base_q;
    mem_we_d     = 1'b0;
    wdata_d      = wdata_q;
`endif

    // pend_q[1] marks the edge where the word read two edges ago is on mem_read_data.
    if (pend_q[1]) begin
      if (mem_read_data < best_hash_q) begin
        best_hash_d  = mem_read_data;
        best_nonce_d = cap_idx_q[7:0];
      end
      if (mem_read_data < target_q) begin
        match_cnt_d = match_cnt_q + 8'd1;
      end
      found_d   = (best_hash_d < target_q);
      cap_idx_d = cap_idx_q + 9'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d   = result_addr;
          target_d     = target;
          issue_cnt_d  = 9'd1;
          cap_idx_d    = '0;
          pend_d       = 2'b01;
          best_hash_d  = 32'hFFFF_FFFF;
          best_nonce_d = '0;
          match_cnt_d  = '0;
          found_d      = 1'b0;
`ifdef SCAN_WRITEBACK_EN
          base_d       = result_addr;
`endif
          state_d      = (N_CNT == 9'd1) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        mem_addr_d  = mem_addr_q + 1'b1;
        issue_cnt_d = issue_cnt_q + 9'd1;
        pend_d[0]   = 1'b1;
        if (issue_cnt_q + 9'd1 == N_CNT) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cap_idx_q == N_CNT) begin
`ifdef SCAN_WRITEBACK_EN
          mem_we_d   = 1'b1;
          mem_addr_d = base_q + N_ADDR;
          wdata_d    = {found_q, 7'b0, match_cnt_q, 8'b0, best_nonce_q};
          state_d    = S_WB0;
`else
          state_d    = S_DONE;
`endif
        end
      end
`ifdef SCAN_WRITEBACK_EN
      S_WB0: begin
        mem_we_d   = 1'b1;
        mem_addr_d = mem_addr_q + 1'b1;
        wdata_d    = best_hash_q;
        state_d    = S_WB1;
      end
      S_WB1: begin
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      target_q     <= '0;
      issue_cnt_q  <= '0;
      cap_idx_q    <= '0;
      pend_q       <= '0;
      best_hash_q  <= 32'hFFFF_FFFF;
      best_nonce_q <= '0;
      match_cnt_q  <= '0;
      found_q      <= 1'b0;
`ifdef SCAN_WRITEBACK_EN
      base_q       <= '0;
      mem_we_q     <= 1'b0;
      wdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      target_q     <= target_d;
      issue_cnt_q  <= issue_cnt_d;
      cap_idx_q    <= cap_idx_d;
      pend_q       <= pend_d;
      best_hash_q  <= best_hash_d;
      best_nonce_q <= best_nonce_d;
      match_cnt_q  <= match_cnt_d;
      found_q      <= found_d;
`ifdef SCAN_WRITEBACK_EN
      base_q       <= base_d;
      mem_we_q     <= mem_we_d;
      wdata_q      <= wdata_d;
`endif
    end
  end

  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign found       = found_q;
  assign best_nonce  = best_nonce_q;
  assign best_hash   = best_hash_q;
  assign match_count = match_cnt_q;
  assign mem_clk     = clk;
  assign mem_addr    = mem_addr_q;
`ifdef SCAN_WRITEBACK_EN
  assign mem_we         = mem_we_q;
  assign mem_write_data = wdata_q;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'h0;
`endif

endmodule

// File: tb/tb_hash_result_scan.sv
// Scoreboard bench for hash_result_scan: a one-register synchronous memory model feeds the scan, expected results are queued at launch.
module tb_hash_result_scan;

  localparam int N = 16;
`ifdef SCAN_WRITEBACK_EN
  localparam int LAT = N + 4;
`else
  localparam int LAT = N + 2;
`endif

  typedef struct packed {
    logic [31:0] hash;
    logic [7:0]  nonce;
    logic        found;
    logic [7:0]  mcount;
    logic [15:0] base;
    logic [31:0] e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done, busy, found;
  logic [7:0]  best_nonce, match_count;
  logic [31:0] best_hash;
  logic        mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          we_cnt = 0;
  exp_t        exp_q[$];
  logic [47:0] wb_q[$];
  exp_t        mon_e;

  hash_result_scan #(.NUM_NONCES(N), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .result_addr(result_addr), .target(target),
    .done(done), .busy(busy), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
    .match_count(match_count), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // clock / memory model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_q <= mem[mem_addr];
  assign mem_read_data = rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: minimum value, first index holding it, count strictly below target
  function automatic exp_t model(input logic [31:0] w[N], input logic [31:0] tgt, input logic [15:0] base);
    exp_t e;
    logic [31:0] lo;
    int first;
    int cnt;
    lo = 32'hFFFF_FFFF;
    foreach (w[k]) if (w[k] < lo) lo = w[k];
    first = 0;
    for (int k = N - 1; k >= 0; k--) if (w[k] == lo) first = k;
    cnt = 0;
    foreach (w[k]) cnt += (w[k] < tgt) ? 1 : 0;
    e.hash   = lo;
    e.nonce  = 8'(first);
    e.found  = (lo < tgt);
    e.mcount = 8'(cnt);
    e.base   = base;
    e.e0     = '0;
    return e;
  endfunction

  // driver: load words, pulse start, push the expected response
  task automatic launch(input logic [15:0] base, input logic [31:0] tgt, input logic [31:0] w[N]);
    exp_t e;
    logic [15:0] a;
    for (int k = 0; k < N; k++) begin
      a = base + 16'(k);
      mem[a] = w[k];
    end
    e = model(w, tgt, base);
    @(negedge clk);
    result_addr = base;
    target      = tgt;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    target = $urandom;
    e.e0   = 32'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      wb_q.push_back({mem_addr, mem_write_data});
    end
    if (done && !reset) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("best_hash", best_hash, mon_e.hash);
        check("best_nonce", 32'(best_nonce), 32'(mon_e.nonce));
        check("found", 32'(found), 32'(mon_e.found));
        check("match_count", 32'(match_count), 32'(mon_e.mcount));
        check("busy_at_done", 32'(busy), 32'd0);
        check("latency", 32'(cyc) - mon_e.e0, 32'(LAT));
`ifdef SCAN_WRITEBACK_EN
        check("wb_count", 32'(wb_q.size()), 32'd2);
        if (wb_q.size() == 2) begin
          check("wb0_addr", 32'(wb_q[0][47:32]), 32'(mon_e.base + 16'(N)));
          check("wb0_data", wb_q[0][31:0], {mon_e.found, 7'b0, mon_e.mcount, 8'b0, mon_e.nonce});
          check("wb1_addr", 32'(wb_q[1][47:32]), 32'(mon_e.base + 16'(N + 1)));
          check("wb1_data", wb_q[1][31:0], mon_e.hash);
        end
`endif
        wb_q.delete();
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_best_nonce"}, 32'(best_nonce), 32'd0);
    check({tag, "_best_hash"}, best_hash, 32'hFFFF_FFFF);
    check({tag, "_match_count"}, 32'(match_count), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_write_data"}, mem_write_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[N];
    int d0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    reset       = 1'b1;
    start       = 1'b0;
    result_addr = '0;
    target      = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ascending words, five below target
    for (int k = 0; k < N; k++) w[k] = 32'h100 + 32'(k);
    launch(16'h0200, 32'h105, w);
    @(negedge clk);
    check("busy_mid_scan", 32'(busy), 32'd1);
    wait_done();

    // descending words, none below target
    for (int k = 0; k < N; k++) w[k] = 32'hF000_0000 - 32'(k);
    launch(16'h1000, 32'h1000_0000, w);
    wait_done();

    // tie at indices 3 and 9
    for (int k = 0; k < N; k++) w[k] = 32'hFFFF_FFFF;
    w[3] = 32'h7;
    w[9] = 32'h7;
    launch(16'h2000, 32'h8, w);
    wait_done();

    // all-ones words
    for (int k = 0; k < N; k++) w[k] = 32'hFFFF_FFFF;
    launch(16'h3000, 32'hFFFF_FFFF, w);
    wait_done();

    // zero target
    for (int k = 0; k < N; k++) w[k] = $urandom_range(0, 1000);
    launch(16'h3100, 32'h0, w);
    wait_done();

    // wrapping addresses plus an ignored start while busy
    for (int k = 0; k < N; k++) w[k] = $urandom_range(0, 300);
    d0 = done_cnt;
    launch(16'hFFF8, 32'd150, w);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (N + 6) @(negedge clk);
    check("single_done_pulse", 32'(done_cnt - d0), 32'd1);

    // reset at E10 aborts the scan
    for (int k = 0; k < N; k++) w[k] = $urandom;
    launch(16'h4000, 32'h8000_0000, w);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    wb_q.delete();
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b0;
    @(negedge clk);
    launch(16'h4000, 32'h8000_0000, w);
    wait_done();

    // random scans
    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < N; k++) begin
        if (k > 0 && $urandom_range(0, 5) == 0) w[k] = w[$urandom_range(0, k - 1)];
        else if ($urandom_range(0, 3) == 0) w[k] = $urandom_range(0, 255);
        else w[k] = $urandom;
      end
      launch(16'($urandom_range(0, 65535)),
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 512)) : $urandom, w);
      wait_done();
    end

`ifndef SCAN_WRITEBACK_EN
    check("no_mem_writes", 32'(we_cnt), 32'd0);
`endif
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
